// File: rtl/bit_serializer.sv
// -----------------------------------------------------------------------------
// bit_serializer
//
// Parallel-to-serial source stage feeding the serial input of seq_ctr. A
// WIDTH-bit word is taken in through a valid/ready handshake and shifted out
// one bit per enabled clock, either MSB first or LSB first. Words can follow
// each other with no idle cycle, and shifting can be stalled with en.
//
// Handshake (load side): a word transfers on a rising edge where
// load_valid && load_ready. The source holds load_valid and din stable until
// that edge; load_ready is combinational and may depend on en.
//
// Ports:
//   clk          clock, rising edge
//   rst          asynchronous, active-low reset
//   din          parallel word to serialize
//   load_valid   din is valid this cycle
//   load_ready   word is accepted this cycle (combinational)
//   en           shift enable; 0 stalls shifting
//   sout         serial bit (0 when idle)
//   sout_valid   sout is a fresh bit this cycle
//   busy         a word is in flight
//   done         one-cycle pulse after the last bit of a word is consumed
//   o_dbg_state  current FSM state (0 = IDLE, 1 = SHIFT)
// -----------------------------------------------------------------------------
module bit_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             en,
  output logic             sout,
  output logic             sout_valid,
  output logic             busy,
  output logic             done,
  output logic             o_dbg_state
);

  localparam int             CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]  LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_sreg;
  logic [CW-1:0]    r_cnt;
  logic             r_done;

  logic w_shift;
  logic w_last;
  logic w_ready;
  logic w_accept;
  logic w_out_bit;

  assign w_shift = (r_state == ST_SHIFT);

  // Last bit is being consumed on this edge; this is also the only moment a
  // busy serializer can take the next word, which keeps back-to-back words
  // gapless.
  assign w_last  = w_shift && en && (r_cnt == LAST_CNT);
  assign w_ready = !w_shift || w_last;

  // While reset is held every flop is forced clear, so the ungated ready is
  // safe to use for the accept decision; only the visible output is masked.
  assign w_accept   = load_valid && w_ready;
  assign load_ready = rst && w_ready;

  assign w_out_bit = MSB_FIRST ? r_sreg[WIDTH-1] : r_sreg[0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_sreg  <= '0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= w_last;
      if (w_accept) begin
        r_sreg  <= din;
        r_cnt   <= '0;
        r_state <= ST_SHIFT;
      end else if (w_last) begin
        r_sreg  <= '0;
        r_cnt   <= '0;
        r_state <= ST_IDLE;
      end else if (w_shift && en) begin
        // Move the next bit into the output position, filling with zero.
        if (MSB_FIRST) begin
          r_sreg <= {r_sreg[WIDTH-2:0], 1'b0};
        end else begin
          r_sreg <= {1'b0, r_sreg[WIDTH-1:1]};
        end
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign sout        = w_shift && w_out_bit;
  assign sout_valid  = w_shift && en;
  assign busy        = w_shift;
  assign done        = r_done;
  assign o_dbg_state = r_state;

endmodule

// File: doc/bit_serializer.md
Name: bit_serializer

Overview:
Parallel-to-serial source stage that sits directly upstream of the sequence counter (seq_ctr) and drives its serial `ip` input. It accepts a WIDTH-bit word through a valid/ready handshake and shifts the word out one bit per clock. It supports back-to-back words with no gap and a shift-enable stall. It pulses `done` when each word completes.

Parameters:
WIDTH, 8, word length in bits; legal range 2..32.
MSB_FIRST, 1, 1 = shift out bit WIDTH-1 first; 0 = shift out bit 0 first.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  asynchronous, active-low reset; clears all state immediately.
din  input  WIDTH  parallel word to serialize.
load_valid  input  1  din is valid this cycle.
load_ready  output  1  block accepts din this cycle (combinational).
en  input  1  shift enable; 0 stalls shifting.
sout  output  1  serial bit; connects to seq_ctr ip.
sout_valid  output  1  sout is a fresh bit this cycle.
busy  output  1  a word is in flight.
done  output  1  one-cycle pulse after the last bit of a word is consumed.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, shift register=0, bit count=0.
  - sout=0, sout_valid=0, busy=0, done=0. load_ready=1 once rst=1.
  - Reset asserted mid-word discards the word. No done pulse is generated for it.
- State machine: two states, IDLE and SHIFT. busy = (state==SHIFT).
- load_ready = IDLE, or (SHIFT and cnt==WIDTH-1 and en). The second term allows back-to-back loads.
- Accept: load_valid && load_ready at a rising edge.
  - sreg <= din, cnt <= 0, state <= SHIFT.
  - Latency: first bit appears on sout in the cycle after the accept edge.
- In SHIFT:
  - sout = sreg[WIDTH-1] (MSB_FIRST=1) or sreg[0] (MSB_FIRST=0).
  - sout_valid = en.
- Shift edge (SHIFT and en=1, cnt<WIDTH-1):
  - sreg shifts toward the output end, filling with 0.
  - cnt <= cnt+1.
- Last-bit edge (SHIFT, en=1, cnt==WIDTH-1):
  - done <= 1 for exactly one cycle.
  - If a load is accepted on the same edge, reload and stay in SHIFT. The next word's first bit follows with zero idle cycles.
  - Otherwise go to IDLE.
- Stall (en=0 in SHIFT):
  - sreg, cnt and sout hold; sout_valid=0; load_ready=0.
  - Stall on the last bit also holds it; done is delayed until en returns.
- load_valid while SHIFT and not on an accepting last-bit edge: ignored, no effect. The source must hold load_valid and din until accepted.
- IDLE: sout=0, sout_valid=0. en has no effect.
- din changes after acceptance have no effect on the word in flight.
- A load on the same edge as reset release is not accepted; reset dominates.
- Each word occupies exactly WIDTH enabled cycles of sout_valid=1.

Test Plan:
- Basic MSB-first (WIDTH=8):
  - Stimulus: reset low 2 cycles, release, load 8'hB4 with en=1.
  - Response: sout sequence 1,0,1,1,0,1,0,0 on 8 consecutive cycles with sout_valid=1.
  - done pulses 1 cycle after the 8th bit; busy=0 afterwards; load_ready=0 for bits 1–7.
- Back-to-back:
  - Stimulus: load_valid held high with 8'hB4 then 8'h0F.
  - Response: 16 contiguous valid bits 1,0,1,1,0,1,0,0,0,0,0,0,1,1,1,1 with no gap.
  - done pulses twice; busy stays 1 throughout.
- Stall:
  - Stimulus: load 8'hB4, drop en for 3 cycles after the 3rd bit.
  - Response: sout holds 1 and sout_valid=0 during the stall; the sequence resumes 1,0,1,0,0; done occurs 3 cycles later than in the basic test.
- LSB-first:
  - Stimulus: MSB_FIRST=0, load 8'hB4.
  - Response: sout sequence 0,0,1,0,1,1,0,1.
- Ignored load:
  - Stimulus: load 8'hB4, then assert load_valid with 8'hFF during bit 4.
  - Response: the B4 bit stream is unchanged; 8'hFF is accepted only on the last-bit edge.
- Reset mid-word:
  - Stimulus: drop rst after the 5th bit of 8'hB4.
  - Response: all outputs are 0 immediately; no done pulse; after release load_ready=1 and a new load works normally.
